// File: rtl/count_pkg.sv
// Shared types and constants for the count sequencer and its prescaler.
package count_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DOWN     = 1'b1;
   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/count_prescaler.sv
// Free-running divider: step pulses whenever the counter matches limit, then restarts.
module count_prescaler #(
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [PRE_W-1:0] limit,
   output logic             step
);

   logic [PRE_W-1:0] cnt;

   assign step = enable && (cnt == limit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable)
         cnt <= step ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/count_sequencer.sv
// Run-control FSM, shadow configuration and count register for the 4-bit counter datapath.
module count_sequencer
   import count_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_limit,
   input  logic             cfg_dir,
   input  logic             cfg_mode,
   input  logic [PRE_W-1:0] cfg_prescale,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tick,
   output logic             done_valid,
   input  logic             done_ready
);

   state_t           state;
   logic [WIDTH-1:0] lim_q;
   logic             dir_q;
   logic             mode_q;
   logic [PRE_W-1:0] pre_q;

   logic             step;
   logic [WIDTH-1:0] start_init;
   logic [WIDTH-1:0] run_init;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] next_cnt;

   assign cfg_ready  = (state == IDLE);
   assign busy       = (state == RUN);
   assign done_valid = (state == DONE);

   // A configuration offered alongside start must seed that run's initial count.
   always_comb begin
      start_init = '0;
      if (cfg_valid) begin
         if (cfg_dir == DIR_DOWN) start_init = cfg_limit;
      end else if (dir_q == DIR_DOWN) begin
         start_init = lim_q;
      end
   end

   assign run_init = (dir_q == DIR_DOWN) ? lim_q : '0;
   assign term     = (dir_q == DIR_DOWN) ? '0 : lim_q;

   // Sitting on the terminal value means the next step reloads; this also makes
   // limit=0 tick on its first step without moving the count.
   always_comb begin
      next_cnt = count;
      if (count == term)
         next_cnt = run_init;
      else if (dir_q == DIR_DOWN)
         next_cnt = count - 1'b1;
      else
         next_cnt = count + 1'b1;
   end

   count_prescaler #(.PRE_W(PRE_W)) u_pre (
      .clk    (clk),
      .rst    (rst),
      .clear  (state == IDLE),
      .enable (state == RUN),
      .limit  (pre_q),
      .step   (step)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         lim_q  <= '0;
         dir_q  <= 1'b0;
         mode_q <= 1'b0;
         pre_q  <= '0;
         count  <= '0;
         tick   <= 1'b0;
      end else begin
         tick <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_valid) begin
                  lim_q  <= cfg_limit;
                  dir_q  <= cfg_dir;
                  mode_q <= cfg_mode;
                  pre_q  <= cfg_prescale;
               end
               if (start) begin
                  state <= RUN;
                  count <= start_init;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
               end else if (step) begin
                  count <= next_cnt;
                  if (next_cnt == term) begin
                     tick <= 1'b1;
                     if (mode_q == MODE_ONESHOT) state <= DONE;
                  end
               end
            end
            DONE: begin
               if (done_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed test-plan scenarios plus random traffic against an arithmetic run model.
module tb_count_sequencer;

   localparam int WIDTH = 4;
   localparam int PRE_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_limit = '0;
   logic             cfg_dir = 1'b0;
   logic             cfg_mode = 1'b0;
   logic [PRE_W-1:0] cfg_prescale = '0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tick;
   logic             done_valid;
   logic             done_ready = 1'b0;

   count_sequencer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_limit    (cfg_limit),
      .cfg_dir      (cfg_dir),
      .cfg_mode     (cfg_mode),
      .cfg_prescale (cfg_prescale),
      .start        (start),
      .stop         (stop),
      .count        (count),
      .busy         (busy),
      .tick         (tick),
      .done_valid   (done_valid),
      .done_ready   (done_ready)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: phase 0=idle 1=run 2=done; t = cycles since run start.
   int m_ph, m_t, m_cnt, m_tick;
   int s_lim, s_dir, s_mode, s_pre;

   function automatic int val_at(input int t);
      int k, r;
      k = t / (s_pre + 1);
      if (s_mode == 1) r = k % (s_lim + 1);
      else             r = (k > s_lim) ? s_lim : k;
      return (s_dir == 1) ? s_lim - r : r;
   endfunction

   task automatic model_reset();
      m_ph = 0; m_t = 0; m_cnt = 0; m_tick = 0;
      s_lim = 0; s_dir = 0; s_mode = 0; s_pre = 0;
   endtask

   task automatic model_edge();
      int steps_to_end;
      m_tick = 0;
      case (m_ph)
         0: begin
            if (cfg_valid) begin
               s_lim = int'(cfg_limit); s_dir = int'(cfg_dir);
               s_mode = int'(cfg_mode); s_pre = int'(cfg_prescale);
            end
            if (start) begin
               m_ph = 1; m_t = 0; m_cnt = (s_dir == 1) ? s_lim : 0;
            end
         end
         1: begin
            if (stop) m_ph = 0;
            else begin
               m_t++;
               m_cnt = val_at(m_t);
               steps_to_end = (s_lim == 0) ? 1 : s_lim;
               if (m_t % (s_pre + 1) == 0) begin
                  if (s_mode == 1)
                     m_tick = (m_cnt == ((s_dir == 1) ? 0 : s_lim)) ? 1 : 0;
                  else if (m_t / (s_pre + 1) == steps_to_end) begin
                     m_tick = 1; m_ph = 2;
                  end
               end
            end
         end
         default: if (done_ready) m_ph = 0;
      endcase
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(m_cnt));
      chk({tag, ".busy"}, 32'(busy), 32'(m_ph == 1));
      chk({tag, ".tick"}, 32'(tick), 32'(m_tick));
      chk({tag, ".done"}, 32'(done_valid), 32'(m_ph == 2));
      chk({tag, ".rdy"}, 32'(cfg_ready), 32'(m_ph == 0));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic quiet();
      cfg_valid = 0; start = 0; stop = 0; done_ready = 0;
   endtask

   task automatic offer(input int l, input int d, input int m, input int p);
      cfg_valid = 1; cfg_limit = WIDTH'(l); cfg_dir = d[0]; cfg_mode = m[0];
      cfg_prescale = PRE_W'(p);
   endtask

   int exp2[8];
   int ticks;

   initial begin
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 0;

      // Up, one-shot, limit 3, prescale 0; config offered with start.
      offer(3, 0, 0, 0); start = 1;
      step("t1");
      quiet();
      chk("t1.c1", 32'(count), 0);
      for (int i = 2; i <= 4; i++) begin
         step("t1");
         chk("t1.cseq", 32'(count), 32'(i - 1));
      end
      chk("t1.tick4", 32'(tick), 1);
      chk("t1.done4", 32'(done_valid), 1);
      chk("t1.busy4", 32'(busy), 0);
      start = 1;
      step("t1.startdone");
      start = 0;
      done_ready = 1;
      step("t1.ack");
      quiet();
      chk("t1.idle", 32'(cfg_ready), 1);

      // Down, auto-reload, limit 2, prescale 1.
      exp2 = '{2, 2, 1, 1, 0, 0, 2, 2};
      offer(2, 1, 1, 1); start = 1;
      step("t2");
      quiet();
      ticks = 0;
      for (int i = 0; i < 13; i++) begin
         if (i < 8) chk("t2.cseq", 32'(count), 32'(exp2[i]));
         if (tick) ticks++;
         if (i == 2) offer(7, 0, 0, 0);
         step("t2");
         cfg_valid = 0;
      end
      chk("t2.ticks", 32'(ticks), 2);
      stop = 1;
      step("t2.stop");
      quiet();

      // Stop coincides with the terminal step.
      offer(5, 0, 0, 0); start = 1;
      step("t3");
      quiet();
      repeat (4) step("t3");
      stop = 1;
      step("t3.stop");
      quiet();
      chk("t3.tick", 32'(tick), 0);
      chk("t3.done", 32'(done_valid), 0);
      chk("t3.idle", 32'(cfg_ready), 1);
      chk("t3.hold", 32'(count), 4);

      // Limit 0, up, one-shot: first step is terminal.
      offer(0, 0, 0, 0); start = 1;
      step("t4");
      quiet();
      step("t4");
      chk("t4.tick", 32'(tick), 1);
      chk("t4.cnt", 32'(count), 0);
      chk("t4.done", 32'(done_valid), 1);
      done_ready = 1;
      step("t4.ack");
      quiet();

      // Asynchronous reset mid-run at count 7.
      offer(9, 0, 0, 0); start = 1;
      step("t5");
      quiet();
      repeat (7) step("t5");
      chk("t5.pre", 32'(count), 7);
      #2 rst = 1;
      #1;
      chk("t5.rcnt", 32'(count), 0);
      chk("t5.rbusy", 32'(busy), 0);
      chk("t5.rtick", 32'(tick), 0);
      chk("t5.rdone", 32'(done_valid), 0);
      model_reset();
      @(negedge clk);
      rst = 0;
      offer(9, 0, 0, 0); start = 1;
      step("t5.re");
      quiet();
      chk("t5.restart", 32'(count), 0);
      stop = 1;
      step("t5.stop");
      quiet();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cfg_valid    = 1'($urandom % 2);
         cfg_limit    = WIDTH'($urandom);
         cfg_dir      = 1'($urandom);
         cfg_mode     = 1'($urandom);
         cfg_prescale = PRE_W'($urandom_range(0, 2));
         start        = ($urandom % 4) == 0;
         stop         = ($urandom % 30) == 0;
         done_ready   = ($urandom % 3) == 0;
         step("rnd");
      end
      quiet();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
